// File: rtl/store_pkg.sv
// Shared definitions for the store unit.
//   size_e    : store size encoding as presented on st_size
//   state_e   : store FSM states
//   LANE_W / NUM_LANES / lane_shift : big-endian byte-lane geometry
//                                     (lane 0 = bits 31:24)
package store_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE     = 2'd0,
    SZ_HALF     = 2'd1,
    SZ_WORD     = 2'd2,
    SZ_WORD_ALT = 2'd3
  } size_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  localparam int LANE_W    = 8;
  localparam int NUM_LANES = 4;

  // Bit offset of the least significant bit of a byte lane. Lane 0 is the
  // most significant byte, so offset = (NUM_LANES-1-lane)*LANE_W.
  function automatic logic [4:0] lane_shift(input logic [1:0] lane);
    return 5'((NUM_LANES - 1 - int'(lane)) * LANE_W);
  endfunction

  function automatic logic size_is_word(input logic [1:0] s);
    return (size_e'(s) == SZ_WORD) || (size_e'(s) == SZ_WORD_ALT);
  endfunction

endpackage

// File: rtl/store_merge.sv
// Combinational byte-lane merge for sub-word stores (big-endian lanes).
// Ports:
//   old_i    : word read back from memory
//   data_i   : store source value, payload in the low-order bits
//   size_i   : store size (size_e encoding)
//   addr_i   : byte offset within the word
//   merged_o : word to write back; untouched lanes keep old_i
module store_merge
  import store_pkg::*;
(
  input  logic [31:0] old_i,
  input  logic [31:0] data_i,
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_i,
  output logic [31:0] merged_o
);

  logic [4:0]  shift;
  logic [31:0] mask;

  always_comb begin
    shift    = 5'd0;
    mask     = 32'h0;
    merged_o = data_i;
    case (size_e'(size_i))
      SZ_BYTE: begin
        shift    = lane_shift(addr_i);
        mask     = 32'h0000_00FF << shift;
        merged_o = (old_i & ~mask) | ({24'h0, data_i[7:0]} << shift);
      end
      SZ_HALF: begin
        // addr[0] is ignored: a half always occupies lanes 0-1 or 2-3,
        // whose low lane (1 or 3) sets the shift.
        shift    = lane_shift({addr_i[1], 1'b1});
        mask     = 32'h0000_FFFF << shift;
        merged_o = (old_i & ~mask) | ({16'h0, data_i[15:0]} << shift);
      end
      default: merged_o = data_i;
    endcase
  end

endmodule

// File: rtl/store_unit.sv
// Store unit: accepts byte/half/word stores and performs them against a
// word-wide memory, using read-modify-write for sub-word sizes.
// Optional feature macro: STORE_ALIGN_CHECK_EN (misaligned half/word stores
// are reported via st_misalign instead of accessing memory).
// Parameter:
//   RD_LAT      : memory read latency in cycles (1..7)
// Ports:
//   clk, reset  : clock, asynchronous active-low reset
//   st_req      : store request, sampled only while idle
//   st_size     : 0=byte 1=half 2/3=word
//   st_addr     : byte address
//   st_data     : store data in low-order bits
//   st_busy     : high in every non-idle state
//   st_done     : one-cycle completion pulse
//   st_misalign : misalignment pulse, coincident with st_done
//   mem_addr    : word-aligned memory address
//   mem_wr      : one-cycle write strobe (low = read)
//   mem_wdata   : merged write word
//   mem_rdata   : read data, valid RD_LAT cycles after the address
//
// Handshake: a request is taken on any rising edge where st_req=1 and
// st_busy=0; st_req is ignored while st_busy=1 (no queueing). Completion is
// signalled by st_done, and the next request may be taken the cycle after.
module store_unit
  import store_pkg::*;
#(
  parameter int RD_LAT = 1
)
(
  input  logic        clk,
  input  logic        reset,
  input  logic        st_req,
  input  logic [1:0]  st_size,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  output logic        st_busy,
  output logic        st_done,
  output logic        st_misalign,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [2:0] RD_LAT_C = 3'(RD_LAT);

  state_e      state_q, state_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] merged;
  logic        req_misaligned;

  store_merge u_merge (
    .old_i    (mem_rdata),
    .data_i   (data_q),
    .size_i   (size_q),
    .addr_i   (addr_q[1:0]),
    .merged_o (merged)
  );

`ifdef STORE_ALIGN_CHECK_EN
  logic misalign_q;

  assign req_misaligned = ((size_e'(st_size) == SZ_HALF) && st_addr[0]) ||
                          (size_is_word(st_size) && (st_addr[1:0] != 2'b00));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      misalign_q <= 1'b0;
    end else if ((state_q == S_IDLE) && st_req) begin
      misalign_q <= req_misaligned;
    end
  end

  assign st_misalign = (state_q == S_DONE) && misalign_q;
`else
  assign req_misaligned = 1'b0;
  assign st_misalign    = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      size_q  <= 2'b00;
      addr_q  <= 32'h0;
      data_q  <= 32'h0;
      wdata_q <= 32'h0;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    size_d  = size_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (st_req) begin
          size_d = st_size;
          addr_d = st_addr;
          data_d = st_data;
          if (req_misaligned) begin
            state_d = S_DONE;
          end else if (size_is_word(st_size)) begin
            wdata_d = st_data;
            state_d = S_WRITE;
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_READ: begin
        cnt_d   = RD_LAT_C;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Count reaching 1 marks the cycle in which mem_rdata is valid.
        if (cnt_q == 3'd1) begin
          wdata_d = merged;
          cnt_d   = 3'd0;
          state_d = S_WRITE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the state register only, so an asynchronous
  // reset clears them (including mem_wr) immediately.
  assign st_busy   = (state_q != S_IDLE);
  assign st_done   = (state_q == S_DONE);
  assign mem_wr    = (state_q == S_WRITE);
  assign mem_addr  = ((state_q == S_READ) || (state_q == S_WAIT) || (state_q == S_WRITE)) ?
                     {addr_q[31:2], 2'b00} : 32'h0;
  assign mem_wdata = (state_q == S_WRITE) ? wdata_q : 32'h0;

endmodule

// File: doc/store_unit.md
STORE_UNIT -- requirements
Module: store_unit

Interface
REQ-001 SHALL have parameter RD_LAT, default 1, memory read latency in cycles (legal 1..7).
REQ-002 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port st_req, input, 1, store request; sampled only in IDLE.
REQ-005 SHALL have port st_size, input, 2, 0=byte, 1=half, 2=word, 3=word.
REQ-006 SHALL have port st_addr, input, 32, byte address of the store.
REQ-007 SHALL have port st_data, input, 32, source register value; the store data sits in the low-order bits.
REQ-008 SHALL have port st_busy, output, 1, high in every non-IDLE state.
REQ-009 SHALL have port st_done, output, 1, one-cycle completion pulse.
REQ-010 SHALL have port st_misalign, output, 1, misalignment exception pulse, coincident with st_done.
REQ-011 SHALL have port mem_addr, output, 32, word-aligned memory address.
REQ-012 SHALL have port mem_wr, output, 1, memory write strobe; low means read.
REQ-013 SHALL have port mem_wdata, output, 32, merged write word.
REQ-014 SHALL have port mem_rdata, input, 32, memory read data, valid RD_LAT cycles after the address.

Function
REQ-015 SHALL implement FSM states IDLE, READ, WAIT, WRITE and DONE.
REQ-016 SHALL latch st_size, st_addr and st_data in IDLE when st_req=1, then go to WRITE for a word store or to READ for a byte or half store.
REQ-017 SHALL ignore st_req in every non-IDLE state; no queueing.
REQ-018 SHALL drive mem_addr={addr[31:2],2'b00} from the latched address in READ, WAIT and WRITE, and hold it stable across those states.
REQ-019 SHALL go from READ to WAIT, stay in WAIT for RD_LAT cycles using a down-counter, and capture mem_rdata on the last WAIT cycle.
REQ-020 SHALL merge the store data big-endian into the captured word: a byte goes to lane addr[1:0] (lane 0 = bits 31:24); a half goes to bits 31:16 when addr[1]=0 and to bits 15:0 otherwise; other bits keep the read value.
REQ-021 SHALL, for a word store, set mem_wdata=st_data with no read phase.
REQ-022 SHALL assert mem_wr for exactly one cycle, in WRITE, and then go to DONE.
REQ-023 SHALL pulse st_done for one cycle in DONE and then return to IDLE.
REQ-024 SHALL give these latencies, counting the acceptance cycle as 0: word store has WRITE at cycle 1 and st_done at cycle 2; byte or half store has st_done at cycle 3+RD_LAT.
REQ-025 SHALL accept a new st_req in the cycle after DONE (back-to-back).

Reset
REQ-026 SHALL, while reset=0, force state=IDLE, st_busy=0, st_done=0, st_misalign=0, mem_wr=0, mem_addr=0, mem_wdata=0 and the counter to 0.
REQ-027 SHALL, on reset mid-operation, drop mem_wr immediately with no write completed and no st_done pulse.

Configuration
REQ-028 SHALL, with STORE_ALIGN_CHECK_EN defined, treat a half store with addr[0]=1 or a word store with addr[1:0]!=0 as misaligned: no memory access, go directly IDLE->DONE, st_misalign=1 together with st_done.
REQ-029 SHALL, without STORE_ALIGN_CHECK_EN, tie st_misalign to 0, ignore addr[0] for half stores and ignore addr[1:0] for word stores.

Structure
REQ-030 SHALL take the size encoding enum, the FSM state enum and the byte-lane constants from the shared package store_pkg.
REQ-031 SHALL place the lane merge in a combinational sub-module store_merge (inputs: old word, data, size, addr[1:0]; output: merged word).

Verification
REQ-032 SHALL cover: word store, addr=0x100, data=0xDEADBEEF -> mem_wr=1 at cycle 1 with mem_addr=0x100, st_done at cycle 2, no read cycle.
REQ-033 SHALL cover: byte store, addr=0x101, data=0x000000AA, memory word=0x11223344, RD_LAT=1 -> write of 0x11AA3344 at cycle 3, st_done at cycle 4.
REQ-034 SHALL cover: half store, addr=0x102, data=0x0000BEEF, memory word=0x11223344 -> write of 0x1122BEEF; with RD_LAT=3, st_done at cycle 6.
REQ-035 SHALL cover: st_req held high for 10 cycles -> back-to-back word stores with no overlap, st_busy low only in acceptance cycles.
REQ-036 SHALL cover: reset asserted in WAIT -> mem_wr never pulses, no st_done, all outputs 0; a fresh store afterwards completes correctly.
REQ-037 SHALL cover: word store to addr=0x102 -> with STORE_ALIGN_CHECK_EN, st_misalign and st_done at cycle 1 with mem_wr=0; without the macro, mem_addr=0x100 is written normally.
